// File: rtl/lcd1602_pkg.sv
// Shared types and constants for the LCD1602 write-only controller.
// The optional power-on init ROM is enabled with the LCD1602_INIT_EN macro.
package lcd1602_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT  = 3'd0,
        INIT_LOAD = 3'd1,
        IDLE      = 3'd2,
        SETUP     = 3'd3,
        EN_HI     = 3'd4,
        EXEC_WAIT = 3'd5
    } state_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // entry mode: increment

    localparam int INIT_LEN = 4;
    localparam logic [7:0] INIT_ROM [0:INIT_LEN-1] =
        '{CMD_FUNC_SET, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY};

    // Clear (0x01), home (0x02/0x03) and the 0x00 command share the long wait.
    function automatic logic uses_clr_wait(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && (data[7:1] <= 7'd1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd1602_ctrl_if.sv
// Upstream byte interface of the LCD1602 controller.
// A byte moves when in_valid and in_ready are both high on a rising clock
// edge; the producer holds in_valid, in_rs and in_data stable until then,
// and the controller ignores them while in_ready is low.
interface lcd1602_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;

    modport master (output in_valid, output in_rs, output in_data, input in_ready);
    modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd1602_timer.sv
// Loadable down-counter shared by every timed state; stops at zero.
module lcd1602_timer #(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over counting; the count parks at zero until reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd1602_ctrl.sv
// HD44780/LCD1602 write-only bus controller: E-strobe timing, execution
// waits and power-up wait. Define LCD1602_INIT_EN to replay the init ROM
// after power-up; without it the block goes straight to IDLE.
module lcd1602_ctrl
    import lcd1602_pkg::*;
#(
    parameter int SETUP_CYC    = 5,
    parameter int EN_HIGH_CYC  = 25,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 82000,
    parameter int POWERUP_CYC  = 2000000
) (
    input  logic                 clock_50mhz,
    input  logic                 reset,
    lcd1602_ctrl_if.slave        up,
    output logic                 init_done,
    output logic [7:0]           lcd_data,
    output logic                 lcd_EN,
    output logic                 lcd_RS,
    output logic                 lcd_RW,
    output state_t               dbg_state
);

    localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, EN_HIGH_CYC),
                                             max_int(CMD_WAIT_CYC, CLR_WAIT_CYC)),
                                     POWERUP_CYC);
    localparam int CW = $clog2(MAX_CYC) + 1;

    // Each state lasts N cycles: the counter is loaded with N-1 on entry.
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LD   = CW'(CLR_WAIT_CYC - 1);
    localparam logic [CW-1:0] PWR_LD   = CW'(POWERUP_CYC - 1);

    state_t          state;
    logic            timer_load;
    logic [CW-1:0]   timer_val;
    logic            timer_zero;
`ifdef LCD1602_INIT_EN
    logic [1:0]      init_idx;
`endif

    assign lcd_RW    = 1'b0;
    assign dbg_state = state;

    lcd1602_timer #(
        .W         (CW),
        .RESET_VAL (PWR_LD)
    ) u_timer (
        .clk      (clock_50mhz),
        .rst      (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Reload the shared counter on every transition into a timed state.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
`ifdef LCD1602_INIT_EN
            INIT_LOAD: begin
                timer_load = 1'b1;
                timer_val  = SETUP_LD;
            end
`endif
            IDLE: begin
                if (up.in_valid) begin
                    timer_load = 1'b1;
                    timer_val  = SETUP_LD;
                end
            end
            SETUP: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = EN_LD;
                end
            end
            EN_HI: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = uses_clr_wait(lcd_RS, lcd_data) ? CLR_LD : CMD_LD;
                end
            end
            default: ;
        endcase
    end

    // Main sequencer; all pin outputs and in_ready are registered here.
    always_ff @(posedge clock_50mhz or posedge reset) begin
        if (reset) begin
            state       <= PWR_WAIT;
            lcd_EN      <= 1'b0;
            lcd_RS      <= 1'b0;
            lcd_data    <= 8'h00;
            up.in_ready <= 1'b0;
            init_done   <= 1'b0;
`ifdef LCD1602_INIT_EN
            init_idx    <= '0;
`endif
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (timer_zero) begin
`ifdef LCD1602_INIT_EN
                        state       <= INIT_LOAD;
`else
                        state       <= IDLE;
                        up.in_ready <= 1'b1;
                        init_done   <= 1'b1;
`endif
                    end
                end
`ifdef LCD1602_INIT_EN
                INIT_LOAD: begin
                    lcd_data <= INIT_ROM[init_idx];
                    lcd_RS   <= 1'b0;
                    state    <= SETUP;
                end
`endif
                IDLE: begin
                    if (up.in_valid) begin
                        lcd_data    <= up.in_data;
                        lcd_RS      <= up.in_rs;
                        up.in_ready <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer_zero) begin
                        lcd_EN <= 1'b1;
                        state  <= EN_HI;
                    end
                end
                EN_HI: begin
                    if (timer_zero) begin
                        lcd_EN <= 1'b0;
                        state  <= EXEC_WAIT;
                    end
                end
                EXEC_WAIT: begin
                    if (timer_zero) begin
`ifdef LCD1602_INIT_EN
                        // init_done low means the init ROM is still being issued.
                        if (!init_done && (init_idx != 2'(INIT_LEN - 1))) begin
                            init_idx <= init_idx + 2'd1;
                            state    <= INIT_LOAD;
                        end else begin
                            init_done   <= 1'b1;
                            up.in_ready <= 1'b1;
                            state       <= IDLE;
                        end
`else
                        init_done   <= 1'b1;
                        up.in_ready <= 1'b1;
                        state       <= IDLE;
`endif
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// Self-checking bench for lcd1602_ctrl with reduced timing parameters.
// Follows LCD1602_INIT_EN so the same bench covers both builds.
module tb_lcd1602_ctrl;
    import lcd1602_pkg::*;

    localparam int S    = 2;
    localparam int E    = 3;
    localparam int CMDW = 10;
    localparam int CLRW = 40;
    localparam int P    = 20;

`ifdef LCD1602_INIT_EN
    localparam int N_INIT = 4;
    logic [7:0] init_bytes [0:3] = '{8'h38, 8'h0C, 8'h01, 8'h06};
`else
    localparam int N_INIT = 0;
    logic [7:0] init_bytes [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_EN;
    logic       lcd_RS;
    logic       lcd_RW;
    state_t     dbg_state;

    lcd1602_ctrl_if up();

    lcd1602_ctrl #(
        .SETUP_CYC    (S),
        .EN_HIGH_CYC  (E),
        .CMD_WAIT_CYC (CMDW),
        .CLR_WAIT_CYC (CLRW),
        .POWERUP_CYC  (P)
    ) dut (
        .clock_50mhz (clk),
        .reset       (rst),
        .up          (up),
        .init_done   (init_done),
        .lcd_data    (lcd_data),
        .lcd_EN      (lcd_EN),
        .lcd_RS      (lcd_RS),
        .lcd_RW      (lcd_RW),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- pin monitor ----------------
    logic [8:0] pulse_q [$];
    int         rise_q  [$];
    int         width_q [$];
    logic [8:0] exp_q   [$];
    logic       prev_en    = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_done  = 1'b0;
    int         rise_cyc   = 0;
    logic [8:0] rise_val   = '0;
    int         ready_rise = -1;
    int         done_rise  = -1;
    int         hold_err   = 0;
    int         rw_err     = 0;

    always @(negedge clk) begin
        if (lcd_RW !== 1'b0) rw_err++;
        if (lcd_EN === 1'b1 && prev_en !== 1'b1) begin
            rise_cyc = cyc;
            rise_val = {lcd_RS, lcd_data};
            pulse_q.push_back({lcd_RS, lcd_data});
            rise_q.push_back(cyc);
        end else if (lcd_EN === 1'b1 && {lcd_RS, lcd_data} !== rise_val) begin
            hold_err++;
        end
        if (lcd_EN !== 1'b1 && prev_en === 1'b1) width_q.push_back(cyc - rise_cyc);
        if (up.in_ready === 1'b1 && prev_ready !== 1'b1) ready_rise = cyc;
        if (init_done === 1'b1 && prev_done !== 1'b1) done_rise = cyc;
        prev_en    = lcd_EN;
        prev_ready = up.in_ready;
        prev_done  = init_done;
    end

    // ---------------- reference model ----------------
    function automatic int exp_wait(input logic rs, input logic [7:0] data);
        if (rs == 1'b0 && data < 8'd4) return CLRW;
        return CMDW;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        pulse_q.delete();
        rise_q.delete();
        width_q.delete();
        ready_rise = -1;
        done_rise  = -1;
    endtask

    task automatic do_release(output int rel);
        @(negedge clk);
        #1;
        clear_mon();
        rst = 1'b0;
        rel = cyc;
    endtask

    // Presents a byte and returns the cycle index seen just after the accepting edge.
    task automatic send_byte(input logic rs, input logic [7:0] data, output int acc, output bit ok);
        up.in_valid = 1'b1;
        up.in_rs    = rs;
        up.in_data  = data;
        ok  = 1'b0;
        acc = 0;
        for (int k = 0; k < 300; k++) begin
            if (up.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cyc;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (ready_rise != -1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++; if (lcd_EN !== 1'b0)       begin bad++; $display("FAIL reset_en got=%b want=0", lcd_EN); end
        total++; if (lcd_RS !== 1'b0)       begin bad++; $display("FAIL reset_rs got=%b want=0", lcd_RS); end
        total++; if (lcd_RW !== 1'b0)       begin bad++; $display("FAIL reset_rw got=%b want=0", lcd_RW); end
        total++; if (lcd_data !== 8'h00)    begin bad++; $display("FAIL reset_data got=%h want=00", lcd_data); end
        total++; if (up.in_ready !== 1'b0)  begin bad++; $display("FAIL reset_ready got=%b want=0", up.in_ready); end
        total++; if (init_done !== 1'b0)    begin bad++; $display("FAIL reset_init_done got=%b want=0", init_done); end
        total++; if (dbg_state !== PWR_WAIT) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, PWR_WAIT); end
    endtask

    // Power-up wait plus init ROM replay (empty ROM in the init-disabled build).
    task automatic test_init(input int rel);
        bit ok;
        int exp_rise;
        int exp_ready;
        wait_ready(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL init_timeout got=no in_ready want=in_ready within budget");
            return;
        end
        exp_rise  = rel + P + 1 + S;
        exp_ready = rel + P;
        total++;
        if (pulse_q.size() != N_INIT) begin
            bad++;
            $display("FAIL init_pulse_count got=%0d want=%0d", pulse_q.size(), N_INIT);
        end else begin
            for (int i = 0; i < N_INIT; i++) begin
                total++;
                if (pulse_q[i] !== {1'b0, init_bytes[i]}) begin
                    bad++; $display("FAIL init_byte%0d got=%h want=%h", i, pulse_q[i], {1'b0, init_bytes[i]});
                end
                total++;
                if (rise_q[i] != exp_rise) begin
                    bad++; $display("FAIL init_rise%0d got=%0d want=%0d", i, rise_q[i] - rel, exp_rise - rel);
                end
                total++;
                if (width_q[i] != E) begin
                    bad++; $display("FAIL init_width%0d got=%0d want=%0d", i, width_q[i], E);
                end
                exp_ready = exp_rise + E + exp_wait(1'b0, init_bytes[i]);
                exp_rise  = exp_ready + 1 + S;
            end
        end
        total++;
        if (ready_rise != exp_ready) begin
            bad++; $display("FAIL init_ready_time got=%0d want=%0d", ready_rise - rel, exp_ready - rel);
        end
        total++;
        if (done_rise != ready_rise) begin
            bad++; $display("FAIL init_done_align got=%0d want=%0d", done_rise - rel, ready_rise - rel);
        end
    endtask

    task automatic write_one(input logic rs, input logic [7:0] data);
        int acc;
        bit ok;
        int w;
        w = exp_wait(rs, data);
        clear_mon();
        send_byte(rs, data, acc, ok);
        up.in_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL wr_accept rs=%b data=%h got=no accept want=accept", rs, data);
            return;
        end
        @(negedge clk);
        #1;
        total++;
        if (up.in_ready !== 1'b0) begin
            bad++; $display("FAIL wr_ready_drop got=%b want=0", up.in_ready);
        end
        wait_ready(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL wr_timeout data=%h got=no in_ready want=in_ready", data);
            return;
        end
        total++;
        if (pulse_q.size() != 1) begin
            bad++; $display("FAIL wr_pulse_count data=%h got=%0d want=1", data, pulse_q.size());
        end else begin
            total++;
            if (pulse_q[0] !== {rs, data}) begin
                bad++; $display("FAIL wr_value got=%h want=%h", pulse_q[0], {rs, data});
            end
            total++;
            if (rise_q[0] != acc + S) begin
                bad++; $display("FAIL wr_en_rise data=%h got=%0d want=%0d", data, rise_q[0] - acc, S);
            end
            total++;
            if (width_q.size() != 1 || width_q[0] != E) begin
                bad++; $display("FAIL wr_en_width data=%h got=%0d want=%0d", data,
                                (width_q.size() > 0) ? width_q[0] : -1, E);
            end
        end
        total++;
        if (ready_rise != acc + S + E + w) begin
            bad++; $display("FAIL wr_occupancy rs=%b data=%h got=%0d want=%0d", rs, data, ready_rise - acc, S + E + w);
        end
        total++;
        if ({lcd_RS, lcd_data} !== {rs, data}) begin
            bad++; $display("FAIL wr_idle_hold got=%h want=%h", {lcd_RS, lcd_data}, {rs, data});
        end
    endtask

    task automatic test_data_write();
        write_one(1'b1, 8'h41);
    endtask

    task automatic test_clear_wait();
        write_one(1'b0, 8'h01);
        write_one(1'b0, 8'h02);
        write_one(1'b0, 8'h80);
        write_one(1'b0, 8'h00);
        write_one(1'b0, 8'h03);
        write_one(1'b1, 8'h01);
        write_one(1'b0, 8'h04);
    endtask

    task automatic test_random();
        logic       rs;
        logic [7:0] data;
        for (int i = 0; i < 10; i++) begin
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) data = 8'($urandom_range(0, 3));
            else                           data = 8'($urandom_range(0, 255));
            write_one(rs, data);
        end
    endtask

    task automatic test_back_to_back();
        int         accs  [0:2];
        int         waits [0:2];
        logic       rs;
        logic [7:0] data;
        logic [8:0] exp;
        bit         ok;
        clear_mon();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            rs   = 1'($urandom_range(0, 1));
            data = 8'($urandom_range(0, 63));
            data[7:6] = 2'(i);
            exp_q.push_back({rs, data});
            waits[i] = exp_wait(rs, data);
            send_byte(rs, data, accs[i], ok);
            if (!ok) begin
                up.in_valid = 1'b0;
                total++; bad++;
                $display("FAIL b2b_accept%0d got=no accept want=accept", i);
                return;
            end
        end
        up.in_valid = 1'b0;
        ready_rise  = -1;
        wait_ready(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL b2b_timeout got=no in_ready want=in_ready");
            return;
        end
        total++;
        if (pulse_q.size() != 3) begin
            bad++; $display("FAIL b2b_pulse_count got=%0d want=3", pulse_q.size());
            return;
        end
        for (int i = 0; i < 3; i++) begin
            exp = exp_q.pop_front();
            total++;
            if (pulse_q[i] !== exp) begin
                bad++; $display("FAIL b2b_order%0d got=%h want=%h", i, pulse_q[i], exp);
            end
            total++;
            if (rise_q[i] != accs[i] + S) begin
                bad++; $display("FAIL b2b_rise%0d got=%0d want=%0d", i, rise_q[i] - accs[i], S);
            end
            if (i < 2) begin
                total++;
                if (accs[i+1] - accs[i] != S + E + waits[i] + 1) begin
                    bad++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", i, accs[i+1] - accs[i], S + E + waits[i] + 1);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int acc;
        int rel;
        bit ok;
        bit seen;
        clear_mon();
        send_byte(1'b1, 8'h5A, acc, ok);
        up.in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (lcd_EN === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!ok || !seen) begin
            bad++; $display("FAIL mr_en_seen got=%b want=1", seen);
            return;
        end
        #2;
        rst = 1'b1;
        #1;
        total++; if (lcd_EN !== 1'b0)      begin bad++; $display("FAIL mr_en got=%b want=0", lcd_EN); end
        total++; if (lcd_data !== 8'h00)   begin bad++; $display("FAIL mr_data got=%h want=00", lcd_data); end
        total++; if (lcd_RS !== 1'b0)      begin bad++; $display("FAIL mr_rs got=%b want=0", lcd_RS); end
        total++; if (up.in_ready !== 1'b0) begin bad++; $display("FAIL mr_ready got=%b want=0", up.in_ready); end
        total++; if (init_done !== 1'b0)   begin bad++; $display("FAIL mr_init_done got=%b want=0", init_done); end
        repeat (3) @(negedge clk);
        do_release(rel);
        test_init(rel);
    endtask

    task automatic test_pins();
        total++;
        if (rw_err != 0) begin
            bad++; $display("FAIL rw_low got=%0d nonzero samples want=0", rw_err);
        end
        total++;
        if (hold_err != 0) begin
            bad++; $display("FAIL en_hold got=%0d changes want=0", hold_err);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        int rel;
        up.in_valid = 1'b0;
        up.in_rs    = 1'b0;
        up.in_data  = 8'h00;
        #1;
        rst = 1'b1;
        test_reset();
        do_release(rel);
        test_init(rel);
        test_data_write();
        test_clear_wait();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_data_write();
        test_pins();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd1602_ctrl.md
# lcd1602_ctrl

Write-only HD44780/LCD1602 bus controller, driving `lcd_data`, `lcd_EN`, `lcd_RS` and `lcd_RW` straight from fabric logic. It sits between a byte producer and the LCD pins:
- **Upstream:** a CPU PIO or a text-formatter FSM, connected through a valid/ready handshake.
- **Downstream:** the LCD pins.

It generates the E-pulse setup/width timing and the post-command execution delays. It also runs the power-on init sequence, so upstream logic never handles LCD timing.

## Interface
- `SETUP_CYC`, default 5: cycles with RS/data stable and EN low before the EN rising edge (100 ns at 50 MHz).
- `EN_HIGH_CYC`, default 25: EN high width in cycles (500 ns).
- `CMD_WAIT_CYC`, default 2500: execution wait after a normal command or data write (50 µs).
- `CLR_WAIT_CYC`, default 82000: execution wait after clear/home commands (1.64 ms).
- `POWERUP_CYC`, default 2000000: wait after reset before the first LCD access (40 ms).

Ports:
- `clock_50mhz` in 1: system clock. This is the single clock for the block.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: the upstream byte is valid.
- `in_ready` out 1: the controller accepts a byte this cycle.
- `in_rs` in 1: 0 = command, 1 = data (DDRAM/CGRAM write).
- `in_data` in 8: the byte to write.
- `init_done` out 1: the power-up wait and init sequence are complete. Stays high until reset.
- `lcd_data` out 8: LCD DB7..DB0.
- `lcd_EN` out 1: LCD enable strobe.
- `lcd_RS` out 1: LCD register select.
- `lcd_RW` out 1: LCD read/write. Always 0 (write-only).

## Operation
- Reset values: `lcd_EN`=0, `lcd_RS`=0, `lcd_RW`=0, `lcd_data`=8'h00, `in_ready`=0, `init_done`=0. Reset also sets the FSM to `PWR_WAIT`.
- FSM states and transitions:
  - `PWR_WAIT`: counts `POWERUP_CYC`, then goes to `INIT_LOAD`.
  - `INIT_LOAD`: loads the next init byte (RS=0), then goes to `SETUP`.
  - `IDLE`: `in_ready`=1. On `in_valid`, latches `in_rs`/`in_data` and goes to `SETUP`.
  - `SETUP`: goes to `EN_HI`.
  - `EN_HI`: goes to `EXEC_WAIT`.
  - `EXEC_WAIT`: goes back to `INIT_LOAD` while init bytes remain. Otherwise it sets `init_done` and goes to `IDLE`.
- The handshake is valid/ready. A transfer occurs when `in_valid` and `in_ready` are both high on a rising clock edge. `in_ready` is high only in `IDLE`. Upstream must hold `in_valid` and its byte stable until accepted. Input changes while `in_ready`=0 are ignored.
- The latched byte and RS are driven on `lcd_data`/`lcd_RS` from `SETUP` through the end of `EXEC_WAIT`. They stay at the last value while in `IDLE`.
- Wait selection: `CLR_WAIT_CYC` applies when RS=0 and `data[7:1]`==7'b0000000 (clear 8'h01) or `data[7:1]`==7'b0000001 (home 8'h02/8'h03). All other bytes use `CMD_WAIT_CYC`.
- A RS=0, 8'h00 write is a legal command and uses `CLR_WAIT_CYC`, because 7'b0000000 matches.
- There is a single shared down-counter. Its width is `$clog2` of the largest parameter plus 1. It loads N-1 on state entry, and the state exits when the count is 0.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously). The full power-up wait and init sequence rerun. An in-flight byte is dropped.

## Timing
- Transfer on edge t. Cycles numbered as edge t+1 onward:
  - t+1 … t+`SETUP_CYC`: RS/data valid, EN=0.
  - t+`SETUP_CYC`+1 … t+`SETUP_CYC`+`EN_HIGH_CYC`: EN=1.
  - Next `CMD_WAIT_CYC` or `CLR_WAIT_CYC` cycles: EN=0, data held.
  - `in_ready` returns to 1 on the following cycle.
- Default occupancy for a data write: 5+25+2500 = 2530 cycles after acceptance.
- The maximum accepted throughput is one byte per occupancy period. There is no buffering.
- `init_done` rises on the same edge that `in_ready` first rises.

## Configuration
- Macro: `LCD1602_INIT_EN`.
- Defined: after `PWR_WAIT`, the block issues the init ROM: 8'h38 (8-bit, 2-line, 5x8), 8'h0C (display on, cursor off), 8'h01 (clear), 8'h06 (entry increment). Each byte gets its own execution wait. Only then does it enter `IDLE`.
- Undefined: `INIT_LOAD` is removed. `PWR_WAIT` goes directly to `IDLE` and sets `init_done`, and upstream is responsible for the init commands.

## Structure
- Package `lcd1602_pkg` holds:
  - the state enum;
  - the command constants `CMD_FUNC_SET`=8'h38, `CMD_DISP_ON`=8'h0C, `CMD_CLEAR`=8'h01 and `CMD_ENTRY`=8'h06;
  - `INIT_LEN`=4 and the init ROM array.
- One sub-module, `lcd1602_timer`: a loadable down-counter with a `zero` flag, shared by all wait states.

## Test plan
Run with reduced parameters: `SETUP_CYC`=2, `EN_HIGH_CYC`=3, `CMD_WAIT_CYC`=10, `CLR_WAIT_CYC`=40, `POWERUP_CYC`=20.
- **Init sequence:** release reset with `LCD1602_INIT_EN` defined. Expect:
  - 20 idle cycles, then exactly 4 EN pulses carrying 8'h38, 8'h0C, 8'h01, 8'h06 with RS=0, each 3 cycles wide;
  - a 40-cycle gap after 8'h01 and 10-cycle gaps after the others;
  - `init_done` and `in_ready` rising together.
- **Data write:** send RS=1, 8'h41 ('A'). Expect `in_ready` to drop next cycle, EN high on cycles 3–5 after acceptance with data 8'h41 and RS=1, `in_ready` back after 15 cycles, and `lcd_RW`=0 throughout.
- **Clear wait:** send RS=0, 8'h01, then RS=0, 8'h02. Expect a 40-cycle wait for each. Sending RS=0, 8'h80 gives a 10-cycle wait.
- **Back-pressure:** hold `in_valid`=1 with three different bytes queued. Expect exactly three EN pulses in order and no byte dropped or duplicated.
- **Mid-operation reset:** assert `reset` during `EN_HI`. Expect EN=0, data=8'h00 and `in_ready`=0 immediately, followed by the full 20-cycle power-up and init replay.
- **Init disabled:** build without `LCD1602_INIT_EN`. Expect `in_ready`=1 and `init_done`=1 exactly 20 cycles after reset release, with no EN pulses before then.
